fir16_filter: RTL and testbench
===============================

Name: fir16_filter

Overview:
- Fixed-coefficient 16-tap direct-form FIR low-pass filter on signed 16-bit samples.
- Produces a full-precision signed 36-bit output; no rounding, truncation or saturation.
- Structure: 16-deep input sample shift register, then a 16-product multiply-accumulate, then two pipeline register stages.
- One new sample is accepted every clock; there is no handshake.

Parameters:
- DATA_W, 16: input sample width, two's complement.
- COEF_W, 16: coefficient width, two's complement.
- ACC_W, 36: accumulator and output width.
- NTAPS, 16: tap count. Fixed; the coefficient set is only defined for 16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-low: asserted when 0, released when 1.
- sample_in  input  16  signed input sample, captured every rising clk edge.
- y_out  output  36  signed filtered output, registered.

Behaviour:
- Coefficients c[0..15], constant: -84, -53, 120, 240, 350, 420, 450, 460, 460, 450, 420, 350, 240, 120, -53, -84.
  - The set is symmetric; sum = 3806; sum of |c| = 4354.
- Tap register, every rising edge with reset high:
  - tap[0] <= sample_in;
  - tap[k] <= tap[k-1] for k = 1..15.
- MAC: sum = Σ c[k]*tap[k], k = 0..15.
  - Each product is a signed 16x16 = 32-bit value, sign-extended to 36 bits before accumulation.
  - 36 bits cannot overflow: worst case 32768*4354 < 2^35.
- Pipeline:
  - stage0 <= sum;
  - y_out <= stage0.
- Latency: a sample captured into tap[0] at edge N first affects y_out after edge N+2. Measured from the sample_in pin, that is three register stages.
- Throughput: one output per clock, with no stall or bubble.
- Reset (reset = 0, asynchronous):
  - All taps, stage0 and y_out clear to 0 immediately, independent of clk.
  - y_out reads 0 while reset is held.
- Reset release is synchronous in effect: the first edge with reset = 1 captures sample_in.
- Reset asserted mid-stream discards all history. After release, outputs equal those of a freshly reset filter; there is no residue of pre-reset samples.
- From reset release, y_out matches an ideal model (zero-initialised taps, then the same two delays) on every cycle.
- sample_in = -32768 is a legal input and must be handled exactly.

Decomposition:
- Package fir16_pkg holds:
  - DATA_W, COEF_W, ACC_W, NTAPS;
  - a signed 16-bit coefficient type;
  - the constant coefficient array C[0:15];
  - the 36-bit accumulator type.
- Sub-module fir16_mac:
  - takes the 16 taps;
  - computes the products and adder tree;
  - contains stage0 and the output register, giving the 2-cycle registered result.
- fir16_filter keeps the tap shift register and instantiates fir16_mac.
- Splitting the adder tree across the two stages is permitted, provided total latency and results are unchanged.

Test Plan:
- Impulse: reset, then sample_in = 1 for one cycle and 0 thereafter.
  - y_out outputs -84, -53, 120, 240, 350, 420, 450, 460, 460, 450, 420, 350, 240, 120, -53, -84 on consecutive cycles, the first appearing 2 cycles after the impulse is captured into tap[0].
  - y_out is 0 afterwards.
- Step: sample_in held at 200.
  - Output ramps through the partial sums 200*(c[0]+...+c[k]).
  - It settles at 761200 from the 16th loaded sample onward.
- Alternating: sample_in = -100, +100, -100, ...
  - Steady-state y_out = 0, because the alternating-sign coefficient sum is 0.
- Ramp: sample_in = 0, 1, ..., 63.
  - y_out equals Σ c[k]*(n-k) on every cycle, with zero-filled history.
  - Compared cycle-by-cycle against an ideal model with 2-cycle delay.
- Extremes: sample_in held at -32768, then at 32767.
  - Steady-state outputs are -124715008 and 124711202, with no wrap.
- Reset mid-stream: assert reset = 0 asynchronously between edges during the step test.
  - y_out goes to 0 immediately.
  - After release, the response is identical to a fresh start.

Source files
------------

// File: rtl/fir16_pkg.sv
// fir16_pkg
// Shared widths, types and the fixed coefficient set for the 16-tap FIR
// low-pass filter. Imported by the interface, the MAC sub-module and the top.
// No ports (package).
package fir16_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = 36;
    localparam int NTAPS  = 16;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Symmetric low-pass set: sum = 3806, sum of |c| = 4354, so the
    // worst-case accumulation (32768 * 4354) stays below 2^35.
    localparam coef_t C [NTAPS] = '{
        -16'sd84,  -16'sd53,  16'sd120, 16'sd240,
         16'sd350,  16'sd420, 16'sd450, 16'sd460,
         16'sd460,  16'sd450, 16'sd420, 16'sd350,
         16'sd240,  16'sd120, -16'sd53, -16'sd84
    };

endpackage

// File: rtl/fir16_filter_if.sv
// fir16_filter_if
// Sample/result bundle of the FIR filter.
//   sample_in : signed DATA_W input sample, captured every rising clk edge
//   y_out     : signed ACC_W registered filter output
// Modports:
//   master : the sample source / result consumer (drives sample_in)
//   slave  : the filter (drives y_out)
interface fir16_filter_if;
    import fir16_pkg::*;

    sample_t sample_in;
    acc_t    y_out;

    modport master (output sample_in, input y_out);
    modport slave  (input sample_in, output y_out);

endinterface

// File: rtl/fir16_mac.sv
// fir16_mac
// Multiplies the 16 taps by the fixed coefficients, sums the full-precision
// products and registers the result twice (stage0, then the output register).
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous reset, active-low
//   taps   : NTAPS signed samples, taps[0] is the newest
//   y_out  : signed ACC_W result, valid two edges after the taps it reflects
module fir16_mac
    import fir16_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  sample_t taps [NTAPS],
    output acc_t    y_out
);

    localparam int PROD_W = DATA_W + COEF_W;

    typedef logic signed [PROD_W-1:0] prod_t;

    function automatic acc_t sext_prod(input prod_t p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

    prod_t prod [NTAPS];
    acc_t  sum_c;
    acc_t  sum_p0;
    acc_t  y_p1;

    // Operands are widened to the product width first so the signed
    // multiply is exact, including -32768 * coefficient.
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            prod[k] = prod_t'(taps[k]) * prod_t'(C[k]);
        end
    end

    always_comb begin
        sum_c = '0;
        for (int k = 0; k < NTAPS; k++) begin
            sum_c = sum_c + sext_prod(prod[k]);
        end
    end

    // ---- stage p0: accumulated sum / stage p1: output register ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_p0 <= '0;
            y_p1   <= '0;
        end else begin
            sum_p0 <= sum_c;
            y_p1   <= sum_p0;
        end
    end

    assign y_out = y_p1;

endmodule

// File: rtl/fir16_filter.sv
// fir16_filter
// Fixed-coefficient 16-tap direct-form FIR low-pass filter, full-precision
// 36-bit output. One sample accepted per clock, no handshake. A sample
// captured into tap[0] at edge N first shows on y_out after edge N+2.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous reset, active-low; clears taps and pipeline
//   bus   : fir16_filter_if.slave (sample_in in, y_out out)
module fir16_filter
    import fir16_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    fir16_filter_if.slave        bus
);

    sample_t taps [NTAPS];
    acc_t    y_mac;

    // Reset clears the whole history so a mid-stream reset leaves no residue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                taps[k] <= '0;
            end
        end else begin
            taps[0] <= bus.sample_in;
            for (int k = 1; k < NTAPS; k++) begin
                taps[k] <= taps[k-1];
            end
        end
    end

    fir16_mac u_mac (
        .clk   (clk),
        .reset (reset),
        .taps  (taps),
        .y_out (y_mac)
    );

    assign bus.y_out = y_mac;

endmodule

// File: tb/tb_fir16_filter.sv
// tb_fir16_filter
// Directed self-checking bench for fir16_filter: impulse, step with an
// asynchronous mid-stream reset, alternating input, full-scale extremes and
// a ramp checked against the direct convolution formula.
module tb_fir16_filter;
    import fir16_pkg::*;

    logic clk = 1'b0;
    logic reset;

    fir16_filter_if bus ();

    fir16_filter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    localparam int COEF [16] = '{-84, -53, 120, 240, 350, 420, 450, 460,
                                 460, 450, 420, 350, 240, 120, -53, -84};

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint partial(input int k);
        longint s = 0;
        for (int j = 0; j <= k; j++) s += COEF[j];
        return s;
    endfunction

    // Sample changes 1 time unit after an edge (or at a negedge), so the
    // next rising edge captures it; outputs are then read 1 unit later.
    task automatic drive(input int s);
        bus.sample_in = sample_t'(s);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.sample_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", bus.y_out, 0);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_step(input string tag, input int n);
        longint exp;
        for (int i = 0; i < n; i++) begin
            drive(200);
            exp = (i < 2) ? 0 : 200 * partial((i - 2 > 15) ? 15 : i - 2);
            check(tag, bus.y_out, exp);
        end
    endtask

    initial begin
        longint exp;
        int     m;

        reset = 1'b0;
        bus.sample_in = '0;
        #2;
        check("reset_initial", bus.y_out, 0);

        // Impulse response
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive((i == 0) ? 1 : 0);
            exp = (i >= 2 && i < 18) ? COEF[i-2] : 0;
            check("impulse", bus.y_out, exp);
        end

        // Step, interrupted by an asynchronous reset between edges
        do_reset();
        run_step("step_pre", 8);
        #3;
        reset = 1'b0;
        #1;
        check("reset_async", bus.y_out, 0);
        @(posedge clk);
        #1;
        check("reset_held", bus.y_out, 0);
        @(negedge clk);
        reset = 1'b1;
        run_step("step_fresh", 20);
        check("step_settled", bus.y_out, 761200);

        // Alternating input cancels in steady state
        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive((i % 2) ? 100 : -100);
            if (i == 2) check("alt_first", bus.y_out, 8400);
            if (i >= 17) check("alt_steady", bus.y_out, 0);
        end

        // Full-scale extremes
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(-32768);
            if (i >= 17) check("ext_neg", bus.y_out, -124715008);
        end
        for (int i = 0; i < 20; i++) begin
            drive(32767);
            if (i >= 18) check("ext_pos", bus.y_out, 124711202);
        end

        // Ramp against the direct convolution with zero-filled history
        do_reset();
        for (int i = 0; i < 64; i++) begin
            drive(i);
            m = i - 2;
            exp = 0;
            for (int k = 0; k < 16; k++) begin
                if (m - k >= 0) exp += longint'(COEF[k]) * (m - k);
            end
            check("ramp", bus.y_out, exp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
